// File: rtl/obi_sram_banked.sv
// rtl/obi_sram_banked.sv - OBI subordinate SRAM wrapper with word-interleaved banks
//
// Purpose: accepts OBI requests, routes each in-range access to one of
// NumBanks word-interleaved SRAM banks, and returns responses strictly in
// acceptance order through a fall-through response FIFO that honours
// obi_rready_i backpressure. Out-of-range addresses get err=1 and touch no bank.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   obi_req_i      request valid
//   obi_gnt_o      request accepted (depends only on rst_i and the credit count)
//   obi_addr_i     byte address
//   obi_we_i       1 = write
//   obi_be_i       byte enables
//   obi_wdata_i    write data
//   obi_rvalid_o   response valid
//   obi_rready_i   response accepted
//   obi_rdata_o    read data (0 for writes and errors)
//   obi_err_o      error response
module obi_sram_banked #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumBanks  = 2,
  parameter logic [31:0] BaseAddr  = 32'h0,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RspDepth  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   obi_req_i,
  output logic                   obi_gnt_o,
  input  logic [31:0]            obi_addr_i,
  input  logic                   obi_we_i,
  input  logic [3:0]             obi_be_i,
  input  logic [DataWidth-1:0]   obi_wdata_i,
  output logic                   obi_rvalid_o,
  input  logic                   obi_rready_i,
  output logic [DataWidth-1:0]   obi_rdata_o,
  output logic                   obi_err_o
);

  localparam int unsigned Rows   = NumWords / NumBanks;
  localparam int unsigned RowW   = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int unsigned BankSh = $clog2(NumBanks);
  localparam int unsigned BankW  = (NumBanks > 1) ? BankSh : 1;
  localparam int unsigned CntW   = $clog2(RspDepth + 1);
  localparam int unsigned PtrW   = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  typedef struct packed {
    logic             valid;
    logic             err;
    logic             we;
    logic [BankW-1:0] bank;
  } tag_t;

  // Address decode
  logic [31:0]      w_off;
  logic [29:0]      w_word;
  logic             w_in_range;
  logic [BankW-1:0] w_bank;
  logic [RowW-1:0]  w_row;
  logic             w_unused_lsb;

  assign w_off        = obi_addr_i - BaseAddr;
  assign w_word       = w_off[31:2];
  assign w_unused_lsb = ^w_off[1:0];
  // The >= term catches addresses below the window that wrap to a huge offset.
  assign w_in_range   = (obi_addr_i >= BaseAddr) && ({2'b00, w_word} < 32'(NumWords));
  assign w_bank       = w_word[BankW-1:0] & BankW'(NumBanks - 1);
  assign w_row        = RowW'(w_word >> BankSh);

  // Credit: counts everything between accept and response handshake, so the
  // tag pipeline plus FIFO can never hold more than RspDepth entries.
  logic [CntW-1:0] r_outst;
  logic            w_gnt;
  logic            w_acc;

  assign w_gnt     = !rst_i && (r_outst < CntW'(RspDepth));
  assign w_acc     = obi_req_i && w_gnt;
  assign obi_gnt_o = w_gnt;

  // Bank arrays
  logic [NumBanks-1:0]  w_bank_req;
  logic [DataWidth-1:0] r_mem    [NumBanks][Rows];
  logic [DataWidth-1:0] r_bank_q [NumBanks];

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank_req
    assign w_bank_req[b] = w_acc && w_in_range && (w_bank == BankW'(b));
  end

  // No reset: array contents and read registers survive rst_i.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NumBanks; b++) begin
      if (w_bank_req[b]) begin
        if (obi_we_i) begin
          for (int j = 0; j < DataWidth / 8; j++) begin
            if (obi_be_i[j]) begin
              r_mem[b][w_row][8*j +: 8] <= obi_wdata_i[8*j +: 8];
            end
          end
        end else begin
          r_bank_q[b] <= r_mem[b][w_row];
        end
      end
    end
  end

  // Tag pipeline: stage i is visible during cycle t+1+i.
  tag_t r_tag [Latency];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Latency; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= '{valid: w_acc, err: !w_in_range, we: obi_we_i, bank: w_bank};
      for (int i = 1; i < Latency; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Bank output is selected one cycle after accept, before a later access to
  // the same bank can overwrite r_bank_q, then delayed to completion.
  logic [DataWidth-1:0] w_mux0;
  logic [DataWidth-1:0] w_cdata;

  assign w_mux0 = r_bank_q[r_tag[0].bank];

  if (Latency == 1) begin : g_lat1
    assign w_cdata = w_mux0;
  end else begin : g_latn
    logic [DataWidth-1:0] r_sdata [Latency-1];
    always_ff @(posedge clk_i) begin
      r_sdata[0] <= w_mux0;
      for (int k = 1; k < Latency - 1; k++) begin
        r_sdata[k] <= r_sdata[k-1];
      end
    end
    assign w_cdata = r_sdata[Latency-2];
  end

  tag_t               w_ctag;
  logic [DataWidth:0] w_centry;

  assign w_ctag   = r_tag[Latency-1];
  assign w_centry = {(w_ctag.we || w_ctag.err) ? '0 : w_cdata, w_ctag.err};

  // Response FIFO, fall-through when empty: a completing entry is shown
  // directly and only stored if it is not taken in the same cycle.
  logic [DataWidth:0] r_fifo [RspDepth];
  logic [PtrW-1:0]    r_rd_ptr;
  logic [PtrW-1:0]    r_wr_ptr;
  logic [CntW-1:0]    r_count;
  logic               w_fifo_empty;
  logic               w_rvalid;
  logic [DataWidth:0] w_head;
  logic               w_pop;
  logic               w_fifo_pop;
  logic               w_push;

  assign w_fifo_empty = (r_count == '0);
  assign w_rvalid     = !rst_i && (!w_fifo_empty || w_ctag.valid);
  assign w_head       = w_fifo_empty ? w_centry : r_fifo[r_rd_ptr];
  assign w_pop        = w_rvalid && obi_rready_i;
  assign w_fifo_pop   = w_pop && !w_fifo_empty;
  assign w_push       = w_ctag.valid && !(w_fifo_empty && obi_rready_i);

  function automatic logic [PtrW-1:0] f_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_outst  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_centry;
        r_wr_ptr         <= f_next(r_wr_ptr);
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_fifo_pop);
      r_outst <= r_outst + CntW'(w_acc) - CntW'(w_pop);
    end
  end

  assign obi_rvalid_o = w_rvalid;
  assign obi_rdata_o  = w_rvalid ? w_head[DataWidth:1] : '0;
  assign obi_err_o    = w_rvalid && w_head[0];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(w_push && (r_count == CntW'(RspDepth))));
      assert (r_outst <= CntW'(RspDepth));
    end
  end

endmodule

// File: tb/tb_obi_sram_banked.sv
// tb/tb_obi_sram_banked.sv - scoreboard bench for obi_sram_banked
module tb_obi_sram_banked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        req    [2];
  logic [31:0] addr   [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] wdata  [2];
  logic        rready [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];

  int tests = 0;
  int fails = 0;
  int acc_cnt [2];
  int last_wait;
  logic [32:0] q0 [$];
  logic [32:0] q1 [$];

  // dut0: base 0, 2 banks, latency 1, depth 2
  obi_sram_banked #(.NumWords(1024), .NumBanks(2), .BaseAddr(32'h0),
                    .Latency(1), .RspDepth(2)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .obi_req_i(req[0]), .obi_gnt_o(gnt[0]),
    .obi_addr_i(addr[0]), .obi_we_i(we[0]), .obi_be_i(be[0]),
    .obi_wdata_i(wdata[0]), .obi_rvalid_o(rvalid[0]), .obi_rready_i(rready[0]),
    .obi_rdata_o(rdata[0]), .obi_err_o(err[0]));

  // dut1: base 0x1000, 64 words, latency 2, depth 3
  obi_sram_banked #(.NumWords(64), .NumBanks(2), .BaseAddr(32'h1000),
                    .Latency(2), .RspDepth(3)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .obi_req_i(req[1]), .obi_gnt_o(gnt[1]),
    .obi_addr_i(addr[1]), .obi_we_i(we[1]), .obi_be_i(be[1]),
    .obi_wdata_i(wdata[1]), .obi_rvalid_o(rvalid[1]), .obi_rready_i(rready[1]),
    .obi_rdata_o(rdata[1]), .obi_err_o(err[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
    int waited = 0;
    bit granted = 0;
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    while (!granted) begin
      @(negedge clk);
      if (gnt[d]) granted = 1;
      else begin
        waited++;
        if (waited > 100) begin
          tests++; fails++;
          $display("FAIL gnt_timeout dut%0d addr %0h: got no gnt expected gnt", d, a);
          break;
        end
      end
    end
    if (granted) begin
      acc_cnt[d]++;
      if (d == 0) q0.push_back({er, ee});
      else        q1.push_back({er, ee});
    end
    last_wait = waited;
    @(posedge clk); #1;
    req[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rvalid[0]) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL rsp0_unexpected: got rvalid data %0h expected no response", rdata[0]);
      end else if (rready[0]) begin
        chk("rsp0", {32'h0, rdata[0], err[0]}, {31'h0, q0.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rvalid[1]) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL rsp1_unexpected: got rvalid data %0h expected no response", rdata[1]);
      end else if (rready[1]) begin
        chk("rsp1", {32'h0, rdata[1], err[1]}, {31'h0, q1.pop_front()});
      end
    end
  end

  initial begin
    int w0, w1, base;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; addr[d] = '0; we[d] = 1'b0;
      be[d] = '0; wdata[d] = '0; rready[d] = 1'b1; acc_cnt[d] = 0;
    end

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_gnt%0d", d), gnt[d], 0);
      chk($sformatf("rst_rvalid%0d", d), rvalid[d], 0);
      chk($sformatf("rst_rdata%0d", d), rdata[d], 0);
      chk($sformatf("rst_err%0d", d), err[d], 0);
      rst[d] = 1'b0;
    end
    @(negedge clk);
    chk("gnt0_after_rst", gnt[0], 1);
    chk("gnt1_after_rst", gnt[1], 1);
    @(posedge clk); #1;

    // Write then read, latency 1
    issue(0, 1, 32'hC, 4'hF, 32'h12345678, 32'h0, 0);
    issue(0, 1, 32'h8, 4'hF, 32'hDEADBEEF, 32'h0, 0);
    chk("wr_rsp_t1_rvalid", rvalid[0], 1);
    chk("wr_rsp_t1_rdata", rdata[0], 0);
    chk("wr_rsp_t1_err", err[0], 0);
    fork
      begin
        issue(0, 0, 32'h8, 4'hF, 32'h0, 32'hDEADBEEF, 0); w0 = last_wait;
        issue(0, 0, 32'hC, 4'hF, 32'h0, 32'h12345678, 0); w1 = last_wait;
      end
      begin
        @(negedge clk);
        chk("bank_req_0x8", dut0.w_bank_req, 2'b01);
        chk("row_0x8", dut0.w_row, 1);
        @(negedge clk);
        chk("bank_req_0xC", dut0.w_bank_req, 2'b10);
      end
    join
    chk("no_stall_rd0", w0, 0);
    chk("no_stall_rd1", w1, 0);

    // Byte enables
    issue(0, 1, 32'h0, 4'hF, 32'hAABBCCDD, 32'h0, 0);
    issue(0, 1, 32'h0, 4'b0101, 32'h11223344, 32'h0, 0);
    issue(0, 0, 32'h0, 4'hF, 32'h0, 32'hAA22CC44, 0);
    issue(0, 1, 32'h0, 4'h0, 32'hFFFFFFFF, 32'h0, 0);
    issue(0, 0, 32'h0, 4'hF, 32'h0, 32'hAA22CC44, 0);

    // Out of range, latency 2, base 0x1000
    fork
      issue(1, 0, 32'h1100, 4'hF, 32'h0, 32'h0, 1);
      begin
        @(negedge clk);
        chk("oor_high_no_bank", dut1.w_bank_req, 2'b00);
      end
    join
    chk("oor_t1_rvalid", rvalid[1], 0);
    @(posedge clk); #1;
    chk("oor_t2_rvalid", rvalid[1], 1);
    chk("oor_t2_err", err[1], 1);
    chk("oor_t2_rdata", rdata[1], 0);
    fork
      issue(1, 0, 32'h0FFC, 4'hF, 32'h0, 32'h0, 1);
      begin
        @(negedge clk);
        chk("oor_low_no_bank", dut1.w_bank_req, 2'b00);
      end
    join
    issue(1, 1, 32'h10FC, 4'hF, 32'h5A5A5A5A, 32'h0, 0);
    issue(1, 0, 32'h10FC, 4'hF, 32'h0, 32'h5A5A5A5A, 0);

    // Backpressure, latency 2, depth 3
    for (int i = 0; i < 5; i++)
      issue(1, 1, 32'h1000 + 32'(4 * i), 4'hF, 32'hB0000000 + 32'(i), 32'h0, 0);
    repeat (4) @(posedge clk);
    #1;
    rready[1] = 1'b0;
    base = acc_cnt[1];
    fork
      begin
        for (int i = 0; i < 5; i++)
          issue(1, 0, 32'h1000 + 32'(4 * i), 4'hF, 32'h0, 32'hB0000000 + 32'(i), 0);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        chk("bp_hold_rdata_a", rdata[1], 32'hB0000000);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_grants", acc_cnt[1] - base, 3);
        chk("bp_gnt_low", gnt[1], 0);
        chk("bp_hold_rvalid", rvalid[1], 1);
        chk("bp_hold_rdata_b", rdata[1], 32'hB0000000);
        rready[1] = 1'b1;
      end
    join
    chk("bp_all_granted", acc_cnt[1] - base, 5);

    // Reset mid-flight
    rready[0] = 1'b0;
    issue(0, 0, 32'h8, 4'hF, 32'h0, 32'hDEADBEEF, 0);
    issue(0, 1, 32'h40, 4'hF, 32'hCAFE0001, 32'h0, 0);
    rst[0] = 1'b1;
    q0.delete();
    @(negedge clk);
    chk("rst_mid_rvalid", rvalid[0], 0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    rready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_dropped", rvalid[0], 0);
    issue(0, 0, 32'h40, 4'hF, 32'h0, 32'hCAFE0001, 0);

    // Drain
    for (int i = 0; i < 100 && (q0.size() + q1.size()) != 0; i++) @(posedge clk);
    #1;
    chk("drain", q0.size() + q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
